// File: rtl/dsp_chain_result_collector.sv
// Capture stage for a cascaded fp16 sum-of-products chain: latency-matched valid/tag tracking,
// show-ahead result FIFO and credit-gated issue. Optional NaN/Inf monitor: COLLECTOR_NAN_CHECK_EN.
module dsp_chain_result_collector #(
  parameter int CHAIN_LAT  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_W      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          issue_valid,
  input  logic [TAG_W-1:0]              issue_tag,
  output logic                          issue_ready,
  input  logic [31:0]                   chain_result,
  output logic                          out_valid,
  output logic [31:0]                   out_data,
  output logic [TAG_W-1:0]              out_tag,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy,
  output logic                          drop_err
`ifdef COLLECTOR_NAN_CHECK_EN
  ,
  output logic                          nan_flag,
  output logic [7:0]                    nan_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam int IW = $clog2(CHAIN_LAT + 1);
  localparam int SW = OW + IW;

  logic             w_accept;
  logic             w_capValid;
  logic [TAG_W-1:0] w_capTag;
  logic [IW-1:0]    w_inflight;
  logic [SW-1:0]    w_used;
  logic             w_push;
  logic             w_pop;

  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [OW-1:0]    r_occupancy;
  logic             r_dropErr;
  logic [31:0]      r_dataMem [FIFO_DEPTH];
  logic [TAG_W-1:0] r_tagMem  [FIFO_DEPTH];

  // In-flight credit excludes this cycle's issue and this cycle's pop, so a push never sees a full FIFO.
  assign w_used      = SW'(r_occupancy) + SW'(w_inflight);
  assign issue_ready = w_used < SW'(FIFO_DEPTH);
  assign w_accept    = issue_valid & issue_ready;

  // Stage 0 is the issue itself; only the later stages are registered, so capture lands at t+CHAIN_LAT-1.
  generate
    if (CHAIN_LAT > 1) begin : g_pipe
      logic [CHAIN_LAT-2:0] r_valid;
      logic [TAG_W-1:0]     r_tag [CHAIN_LAT-1];

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_valid <= '0;
          for (int i = 0; i < CHAIN_LAT - 1; i++) r_tag[i] <= '0;
        end else begin
          r_valid[0] <= w_accept;
          r_tag[0]   <= issue_tag;
          for (int i = 1; i < CHAIN_LAT - 1; i++) begin
            r_valid[i] <= r_valid[i-1];
            r_tag[i]   <= r_tag[i-1];
          end
        end
      end

      always_comb begin
        w_inflight = '0;
        for (int i = 0; i < CHAIN_LAT - 1; i++) w_inflight = w_inflight + IW'(r_valid[i]);
      end

      assign w_capValid = r_valid[CHAIN_LAT-2];
      assign w_capTag   = r_tag[CHAIN_LAT-2];
    end else begin : g_noPipe
      assign w_capValid = w_accept;
      assign w_capTag   = issue_tag;
      assign w_inflight = '0;
    end
  endgenerate

  assign w_push    = w_capValid;
  assign out_valid = r_occupancy != '0;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_dataMem[r_wrPtr] <= chain_result;
      r_tagMem[r_wrPtr]  <= w_capTag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_occupancy <= '0;
      r_dropErr   <= 1'b0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_occupancy <= r_occupancy + OW'(1);
        2'b01:   r_occupancy <= r_occupancy - OW'(1);
        default: r_occupancy <= r_occupancy;
      endcase
      if (issue_valid && !issue_ready) r_dropErr <= 1'b1;
    end
  end

  // Head is masked while empty so stale memory never shows after reset.
  assign out_data  = out_valid ? r_dataMem[r_rdPtr] : 32'h0;
  assign out_tag   = out_valid ? r_tagMem[r_rdPtr] : '0;
  assign occupancy = r_occupancy;
  assign drop_err  = r_dropErr;

`ifdef COLLECTOR_NAN_CHECK_EN
  logic       r_nanFlag;
  logic [7:0] r_nanCount;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_nanFlag  <= 1'b0;
      r_nanCount <= 8'd0;
    end else if (w_push && (chain_result[30:23] == 8'hFF)) begin
      r_nanFlag <= 1'b1;
      if (r_nanCount != 8'hFF) r_nanCount <= r_nanCount + 8'd1;
    end
  end

  assign nan_flag  = r_nanFlag;
  assign nan_count = r_nanCount;
`endif

endmodule
